// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_WAIT = 2'd1,
        IRQ_TAKE = 2'd2,
        IRQ_SERV = 2'd3
    } irq_state_t;

    // Winning hazard row, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        HAZ_NONE     = 3'd0,
        HAZ_MEM_BUSY = 3'd1,
        HAZ_BRANCH   = 3'd2,
        HAZ_IRQ      = 3'd3,
        HAZ_LOAD_USE = 3'd4,
        HAZ_JUMP     = 3'd5
    } haz_sel_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/haz_load_use_det.sv
// Load-use detector: a load in EX whose destination is read by the instruction in ID.
module haz_load_use_det
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    output logic              load_use
);

    // $zero is never a real dependency, so a load targeting it cannot stall.
    assign load_use = ex_mem_read
                    & (ex_rt != REG_AW'(REG_ZERO))
                    & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with interrupt-entry sequencing.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZ_PERF_CNT_EN is defined.
//
// state    | meaning
// IRQ_IDLE | no interrupt activity
// IRQ_WAIT | request seen, waiting for a hazard-free slot
// IRQ_TAKE | redirect PC to the ISR vector this cycle
// IRQ_SERV | ISR running, further requests masked until eret
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRt,
    input  logic              ID_Jump,
    input  logic              EX_MemRead,
    input  logic [REG_AW-1:0] EX_Rt,
    input  logic              EX_BranchTaken,
    input  logic              mem_busy,
    input  logic              irq_in,
    input  logic              eret_in,
    output logic              PC_hold,
    output logic              IF_ID_hold,
    output logic              IF_ID_flush,
    output logic              ID_EX_hold,
    output logic              ID_EX_flush,
    output logic              EX_MEM_hold,
    output logic              irq_take,
    output logic              irq_in_service
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end

    irq_state_t state_q, state_d;
    haz_sel_t   sel;
    logic       load_use;

    haz_load_use_det #(.REG_AW(REG_AW)) u_load_use_det (
        .ex_mem_read (EX_MemRead),
        .ex_rt       (EX_Rt),
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .id_uses_rt  (ID_UsesRt),
        .load_use    (load_use)
    );

    always_comb begin
        sel = HAZ_NONE;
        if (mem_busy)                 sel = HAZ_MEM_BUSY;
        else if (EX_BranchTaken)      sel = HAZ_BRANCH;
        else if (state_q == IRQ_TAKE) sel = HAZ_IRQ;
        else if (load_use)            sel = HAZ_LOAD_USE;
        else if (ID_Jump)             sel = HAZ_JUMP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IRQ_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!mem_busy) begin
            unique case (state_q)
                IRQ_IDLE: if (irq_in) state_d = IRQ_WAIT;
                IRQ_WAIT: begin
                    if (!irq_in)
                        state_d = IRQ_IDLE;
                    else if (!EX_BranchTaken && !load_use && !ID_Jump)
                        state_d = IRQ_TAKE;
                end
                // A taken branch outranks the pulse; stay so the entry is not lost.
                IRQ_TAKE: if (sel == HAZ_IRQ) state_d = IRQ_SERV;
                IRQ_SERV: if (eret_in) state_d = IRQ_IDLE;
                default:  state_d = IRQ_IDLE;
            endcase
        end
    end

    always_comb begin
        PC_hold        = 1'b0;
        IF_ID_hold     = 1'b0;
        IF_ID_flush    = 1'b0;
        ID_EX_hold     = 1'b0;
        ID_EX_flush    = 1'b0;
        EX_MEM_hold    = 1'b0;
        irq_take       = 1'b0;
        irq_in_service = 1'b0;
        if (reset) begin
            irq_in_service = (state_q == IRQ_SERV);
            unique case (sel)
                HAZ_MEM_BUSY: begin
                    PC_hold     = 1'b1;
                    IF_ID_hold  = 1'b1;
                    ID_EX_hold  = 1'b1;
                    EX_MEM_hold = 1'b1;
                end
                HAZ_BRANCH: begin
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end
                HAZ_IRQ: begin
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                    irq_take    = 1'b1;
                end
                HAZ_LOAD_USE: begin
                    PC_hold     = 1'b1;
                    IF_ID_hold  = 1'b1;
                    ID_EX_flush = 1'b1;
                end
                HAZ_JUMP: IF_ID_flush = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (PC_hold && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if ((IF_ID_flush || ID_EX_flush) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the priority mux plus IRQ sequences.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] ID_Rs, ID_Rt, EX_Rt;
    logic              ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken;
    logic              mem_busy, irq_in, eret_in;
    logic              PC_hold, IF_ID_hold, IF_ID_flush, ID_EX_hold;
    logic              ID_EX_flush, EX_MEM_hold, irq_take, irq_in_service;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_Jump        (ID_Jump),
        .EX_MemRead     (EX_MemRead),
        .EX_Rt          (EX_Rt),
        .EX_BranchTaken (EX_BranchTaken),
        .mem_busy       (mem_busy),
        .irq_in         (irq_in),
        .eret_in        (eret_in),
        .PC_hold        (PC_hold),
        .IF_ID_hold     (IF_ID_hold),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_hold     (ID_EX_hold),
        .ID_EX_flush    (ID_EX_flush),
        .EX_MEM_hold    (EX_MEM_hold),
        .irq_take       (irq_take),
        .irq_in_service (irq_in_service)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    // Output vector order: PC_hold IF_ID_hold IF_ID_flush ID_EX_hold ID_EX_flush EX_MEM_hold irq_take irq_in_service
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_BR   = 8'b0010_1000;
    localparam logic [7:0] O_JMP  = 8'b0010_0000;
    localparam logic [7:0] O_MEM  = 8'b1101_0100;
    localparam logic [7:0] O_IRQ  = 8'b0010_1010;
    localparam logic [7:0] O_SERV = 8'b0000_0001;

    typedef struct {
        string       name;
        logic [4:0]  rs, rt, ex_rt;
        logic        uses_rt, jump, mem_read, branch, busy;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [7:0] outs();
        return {PC_hold, IF_ID_hold, IF_ID_flush, ID_EX_hold,
                ID_EX_flush, EX_MEM_hold, irq_take, irq_in_service};
    endfunction

    task automatic chk(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ID_Rs = '0; ID_Rt = '0; EX_Rt = '0;
        ID_UsesRt = 0; ID_Jump = 0; EX_MemRead = 0; EX_BranchTaken = 0;
        mem_busy = 0; irq_in = 0; eret_in = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{"all_quiet",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_NONE};
        vecs[1]  = '{"lu_rs",          5'd5, 5'd1, 5'd5, 1, 0, 1, 0, 0, O_LU};
        vecs[2]  = '{"lu_rt",          5'd1, 5'd5, 5'd5, 1, 0, 1, 0, 0, O_LU};
        vecs[3]  = '{"rt_not_used",    5'd1, 5'd5, 5'd5, 0, 0, 1, 0, 0, O_NONE};
        vecs[4]  = '{"load_zero",      5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, O_NONE};
        vecs[5]  = '{"no_load",        5'd5, 5'd5, 5'd5, 1, 0, 0, 0, 0, O_NONE};
        vecs[6]  = '{"branch_jump",    5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0, O_BR};
        vecs[7]  = '{"jump_only",      5'd2, 5'd3, 5'd0, 1, 1, 0, 0, 0, O_JMP};
        vecs[8]  = '{"busy_over_all",  5'd5, 5'd0, 5'd5, 0, 1, 1, 1, 1, O_MEM};
        vecs[9]  = '{"lu_over_jump",   5'd7, 5'd0, 5'd7, 0, 1, 1, 0, 0, O_LU};
        vecs[10] = '{"busy_only",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, O_MEM};
        vecs[11] = '{"branch_over_lu", 5'd9, 5'd0, 5'd9, 0, 0, 1, 1, 0, O_BR};

        idle_inputs();
        reset = 0;
        mem_busy = 1; EX_BranchTaken = 1; irq_in = 1;
        #12;
        chk("reset_outputs_zero", O_NONE);
        idle_inputs();
        cyc();
        reset = 1;

        for (int i = 0; i < 12; i++) begin
            cyc();
            ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt; EX_Rt = vecs[i].ex_rt;
            ID_UsesRt = vecs[i].uses_rt; ID_Jump = vecs[i].jump;
            EX_MemRead = vecs[i].mem_read; EX_BranchTaken = vecs[i].branch;
            mem_busy = vecs[i].busy;
            #1 chk(vecs[i].name, vecs[i].exp);
        end

        // Load-use stalls once, then the bubble in EX clears it.
        cyc(); idle_inputs();
        EX_MemRead = 1; EX_Rt = 5'd5; ID_Rs = 5'd5; ID_Rt = 5'd1; ID_UsesRt = 1;
        #1 chk("lu_stall_cycle", O_LU);
        cyc(); EX_MemRead = 0;
        #1 chk("lu_after_bubble", O_NONE);

        // IRQ arrives during a taken branch, waits behind a load-use, then enters.
        cyc(); idle_inputs(); irq_in = 1; EX_BranchTaken = 1; ID_Jump = 1;
        #1 chk("irq_during_branch", O_BR);
        cyc(); EX_BranchTaken = 0; ID_Jump = 0;
        EX_MemRead = 1; EX_Rt = 5'd4; ID_Rs = 5'd4;
        #1 chk("wait_behind_lu", O_LU);
        cyc(); EX_MemRead = 0;
        #1 chk("wait_clean_slot", O_NONE);
        cyc();
        #1 chk("irq_take_pulse", O_IRQ);
        cyc();
        #1 chk("serv_irq_masked", O_SERV);
        cyc(); ID_Jump = 1;
        #1 chk("serv_with_jump", O_SERV | O_JMP);
        cyc(); ID_Jump = 0; eret_in = 1;
        #1 chk("serv_eret_cycle", O_SERV);
        cyc(); eret_in = 0;
        #1 chk("after_eret_idle", O_NONE);
        cyc();
        #1 chk("rereq_wait", O_NONE);
        cyc();
        #1 chk("rereq_take", O_IRQ);
        cyc(); irq_in = 0;
        #1 chk("rereq_serv", O_SERV);
        cyc(); eret_in = 1;
        cyc(); eret_in = 0;
        #1 chk("back_idle", O_NONE);

        // Request withdrawn while waiting returns to idle.
        cyc(); irq_in = 1; ID_Jump = 1;
        #1 chk("idle_see_irq", O_JMP);
        cyc(); irq_in = 0; ID_Jump = 0;
        #1 chk("wait_drop", O_NONE);
        cyc();
        #1 chk("dropped_no_take", O_NONE);

        // mem_busy for 3 cycles during IRQ_TAKE defers the single pulse.
        cyc(); irq_in = 1;
        cyc();
        cyc(); mem_busy = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("take_deferred_busy", O_MEM);
            cyc();
        end
        mem_busy = 0;
        #1 chk("take_after_busy", O_IRQ);
        cyc();
        #1 chk("serv_after_busy", O_SERV);

        // Reset while in service clears everything; request must be re-made.
        #2 reset = 0;
        #1 chk("reset_in_serv", O_NONE);
        cyc(); irq_in = 0; reset = 1;
        #1 chk("post_reset_idle", O_NONE);
        cyc(); irq_in = 1;
        #1 chk("post_reset_req", O_NONE);
        cyc();
        #1 chk("post_reset_wait", O_NONE);
        cyc();
        #1 chk("post_reset_take", O_IRQ);
        cyc(); irq_in = 0;
        #1 chk("post_reset_serv", O_SERV);

`ifdef HAZ_PERF_CNT_EN
        cyc(); reset = 0;
        cyc(); idle_inputs(); reset = 1;
        cyc(); EX_MemRead = 1; EX_Rt = 5'd3; ID_Rs = 5'd3;
        cyc(); EX_MemRead = 0;
        cyc(); EX_MemRead = 1; EX_Rt = 5'd6; ID_Rt = 5'd6; ID_UsesRt = 1; ID_Rs = 5'd0;
        cyc(); idle_inputs(); EX_BranchTaken = 1;
        cyc(); EX_BranchTaken = 0;
        #1;
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected 2", stall_cnt);
        end
        checks++;
        if (flush_cnt !== 32'd3) begin
            errors++;
            $display("FAIL flush_cnt: got %0d expected 3", flush_cnt);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
